dircc_node_mem_packet_reader: RTL and testbench

Avalon-MM read master for a node's 16-bit processing-memory port (s2). It fetches a packet of `cmd_len` halfwords starting at `cmd_addr` and emits them on an Avalon-ST source with SOP/EOP framing, under backpressure. Optionally it writes a clear marker back to the packet's first halfword to release the slot. It sits between the processing memory and the node's outbound mailbox/router interface, so the packet move needs no Nios involvement.

---
 rtl/dircc_node_mem_packet_reader_if.sv | 42 ++++
 rtl/dircc_node_mem_packet_reader.sv | 165 ++++++++++++++++
 tb/tb_dircc_node_mem_packet_reader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dircc_node_mem_packet_reader_if.sv
// Command, s2 memory-port and Avalon-ST bundle for the packet reader.
// The reader takes the master modport; its environment takes slave.
interface dircc_node_mem_packet_reader_if #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [1:0]        mem_byteenable;
    logic [15:0]       mem_writedata;
    logic [15:0]       mem_readdata;
    logic              st_valid;
    logic              st_ready;
    logic [15:0]       st_data;
    logic              st_sop;
    logic              st_eop;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        input  mem_readdata, st_ready,
        output cmd_ready, busy, done,
        output mem_address, mem_chipselect, mem_write,
        output mem_byteenable, mem_writedata,
        output st_valid, st_data, st_sop, st_eop
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        output mem_readdata, st_ready,
        input  cmd_ready, busy, done,
        input  mem_address, mem_chipselect, mem_write,
        input  mem_byteenable, mem_writedata,
        input  st_valid, st_data, st_sop, st_eop
    );
endinterface

// File: rtl/dircc_node_mem_packet_reader.sv
// Streams a packet from processing memory (s2) onto Avalon-ST with SOP/EOP.
// Define PKT_READER_CLEAR_EN to write CLEAR_VALUE back to the first halfword.
module dircc_node_mem_packet_reader #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 8
`ifdef PKT_READER_CLEAR_EN
    ,
    parameter logic [15:0] CLEAR_VALUE = 16'h0000
`endif
) (
    input logic clk,
    input logic reset_n,
    dircc_node_mem_packet_reader_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
`ifdef PKT_READER_CLEAR_EN
        S_CLEAR = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              sop_q, sop_d;
    logic              infl_q, infl_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [15:0]       buf0_q, buf0_d;
    logic [15:0]       buf1_q, buf1_d;
`ifdef PKT_READER_CLEAR_EN
    logic [ADDR_W-1:0] base_q, base_d;
`endif

    logic       st_valid;
    logic       pop;
    logic       issue;
    logic       clr_wr;
    logic [2:0] occ;
    logic [1:0] cnt_tmp;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        sop_d      = sop_q;
        infl_d     = 1'b0;
        cnt_d      = cnt_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
`ifdef PKT_READER_CLEAR_EN
        base_d     = base_q;
`endif
        st_valid   = 1'b0;
        pop        = 1'b0;
        issue      = 1'b0;
        occ        = 3'd0;
        cnt_tmp    = 2'd0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d     = bus.cmd_addr;
`ifdef PKT_READER_CLEAR_EN
                    base_d     = bus.cmd_addr;
`endif
                    rd_cnt_d   = bus.cmd_len;
                    beat_cnt_d = bus.cmd_len;
                    sop_d      = 1'b1;
                    cnt_d      = 2'd0;
                    state_d    = (bus.cmd_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                st_valid = (cnt_q != 2'd0);
                pop      = st_valid & bus.st_ready;
                // Buffer plus in-flight read may never exceed two entries.
                occ      = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
                issue    = (rd_cnt_q != '0) && (occ < 3'd2);
                infl_d   = issue;
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
                buf0_d  = pop ? buf1_q : buf0_q;
                cnt_tmp = cnt_q - {1'b0, pop};
                if (infl_q) begin
                    if (cnt_tmp == 2'd0) buf0_d = bus.mem_readdata;
                    else                 buf1_d = bus.mem_readdata;
                end
                cnt_d = cnt_tmp + {1'b0, infl_q};
                if (pop) begin
                    sop_d      = 1'b0;
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == LEN_W'(1)) begin
`ifdef PKT_READER_CLEAR_EN
                        state_d = S_CLEAR;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef PKT_READER_CLEAR_EN
            S_CLEAR: state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            sop_q      <= 1'b0;
            infl_q     <= 1'b0;
            cnt_q      <= 2'd0;
            buf0_q     <= 16'h0000;
            buf1_q     <= 16'h0000;
`ifdef PKT_READER_CLEAR_EN
            base_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            sop_q      <= sop_d;
            infl_q     <= infl_d;
            cnt_q      <= cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
`ifdef PKT_READER_CLEAR_EN
            base_q     <= base_d;
`endif
        end
    end

`ifdef PKT_READER_CLEAR_EN
    assign clr_wr             = (state_q == S_CLEAR);
    assign bus.mem_address    = issue  ? addr_q :
                                clr_wr ? base_q : '0;
    assign bus.mem_writedata  = clr_wr ? CLEAR_VALUE : 16'h0000;
`else
    assign clr_wr             = 1'b0;
    assign bus.mem_address    = issue ? addr_q : '0;
    assign bus.mem_writedata  = 16'h0000;
`endif
    assign bus.mem_chipselect = issue | clr_wr;
    assign bus.mem_write      = clr_wr;
    assign bus.mem_byteenable = 2'b11;

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.st_valid  = st_valid;
    assign bus.st_data   = st_valid ? buf0_q : 16'h0000;
    assign bus.st_sop    = st_valid & sop_q;
    assign bus.st_eop    = st_valid & (beat_cnt_q == LEN_W'(1));
endmodule

// File: tb/tb_dircc_node_mem_packet_reader.sv
// Scoreboard bench: stimulus pushes expected reads, beats, writes and done
// timing; a negedge monitor pops and compares whatever the reader presents.
module tb_dircc_node_mem_packet_reader;
`ifdef PKT_READER_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    typedef struct {
        logic [15:0] d;
        bit          sop;
        bit          eop;
        int          off;
    } beat_t;

    typedef struct {
        logic [13:0] a;
        logic [15:0] d;
        int          off;
    } wr_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   cyc;
    int   t_acc;
    int   pops;
    int   dones;
    int   ndone_exp;
    int   cmd_reads;
    int   rmode;

    beat_t       exp_q[$];
    logic [13:0] exp_rd[$];
    wr_t         exp_wr[$];
    int          exp_done[$];
    logic [15:0] mem [16384];

    dircc_node_mem_packet_reader_if bus ();

    dircc_node_mem_packet_reader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.mem_chipselect && !bus.mem_write)
            bus.mem_readdata <= mem[bus.mem_address];

    function automatic void chk(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endfunction

    task automatic chk_reset();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ctl", {bus.done, bus.mem_chipselect, bus.mem_write,
                        bus.st_valid, bus.st_sop, bus.st_eop}, 0);
        chk("rst_be", bus.mem_byteenable, 3);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_wdata", bus.mem_writedata, 0);
        chk("rst_st_data", bus.st_data, 0);
    endtask

    task automatic send(input logic [13:0] a, input int len, input bit timed);
        logic [13:0] ai;
        for (int i = 0; i < len; i++) begin
            ai = a + 14'(i);
            exp_q.push_back('{mem[ai], i == 0, i == len - 1, timed ? i + 3 : -1});
            exp_rd.push_back(ai);
        end
        if (CLR == 1 && len > 0)
            exp_wr.push_back('{a, 16'h0000, timed ? len + 3 : -1});
        if (!timed)          exp_done.push_back(-1);
        else if (len == 0)   exp_done.push_back(1);
        else                 exp_done.push_back(len + 3 + CLR);
        ndone_exp++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 100 && !bus.cmd_ready; k++) begin
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = 8'(len);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (dones < ndone_exp && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (dones < ndone_exp) chk("done_timeout", dones, ndone_exp);
        #1;
    endtask

    // st_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = held low.
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        bus.st_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    bus.st_ready = pat[k % 4];
                    k++;
                end
                2:       bus.st_ready = 1'b0;
                default: bus.st_ready = 1'b1;
            endcase
        end
    end

    initial begin
        bit pstall;
        bit pdone;
        logic [17:0] pbeat;
        int popped;
        beat_t e;
        wr_t w;
        int lat;
        pstall = 0;
        pdone = 0;
        popped = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pstall = 0;
                pdone = 0;
            end else begin
                if (pstall) begin
                    chk("stall_valid", bus.st_valid, 1);
                    chk("stall_beat", {bus.st_sop, bus.st_eop, bus.st_data}, pbeat);
                end
                if (pdone) chk("ready_after_done", bus.cmd_ready, 1);
                if (bus.cmd_valid && bus.cmd_ready) begin
                    t_acc = cyc;
                    cmd_reads = 0;
                    popped = 0;
                end
                if (bus.st_valid && bus.st_ready) begin
                    pops++;
                    popped++;
                    if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_data", bus.st_data, e.d);
                        chk("beat_sop", bus.st_sop, e.sop);
                        chk("beat_eop", bus.st_eop, e.eop);
                        if (e.off >= 0) chk("beat_cycle", cyc - t_acc, e.off);
                    end
                end
                if (bus.mem_chipselect && !bus.mem_write) begin
                    cmd_reads++;
                    if (exp_rd.size() == 0) chk("read_unexpected", 1, 0);
                    else chk("read_addr", bus.mem_address, exp_rd.pop_front());
                    chk("occupancy_le2", (cmd_reads - popped) <= 2, 1);
                end
                if (bus.mem_chipselect && bus.mem_write) begin
                    if (exp_wr.size() == 0) chk("write_unexpected", 1, 0);
                    else begin
                        w = exp_wr.pop_front();
                        chk("write_addr", bus.mem_address, w.a);
                        chk("write_data", bus.mem_writedata, w.d);
                        if (w.off >= 0) chk("write_cycle", cyc - t_acc, w.off);
                    end
                end
                if (bus.done) begin
                    dones++;
                    if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                    else begin
                        lat = exp_done.pop_front();
                        if (lat >= 0) chk("done_cycle", cyc - t_acc, lat);
                    end
                end
                pstall = bus.st_valid && !bus.st_ready;
                pbeat  = {bus.st_sop, bus.st_eop, bus.st_data};
                pdone  = bus.done;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;
        total = 0;
        bad = 0;
        cyc = 0;
        t_acc = 0;
        pops = 0;
        dones = 0;
        ndone_exp = 0;
        cmd_reads = 0;
        rmode = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'(i) ^ 16'h5A00;
        mem[16'h0010] = 16'h00A1;
        mem[16'h0011] = 16'h00B2;
        mem[16'h0012] = 16'h00C3;
        mem[16'h0013] = 16'h00D4;
        mem[16'h3FFE] = 16'h5EE1;
        mem[16'h3FFF] = 16'h5EE2;
        mem[16'h0000] = 16'h5EE3;
        mem[16'h0300] = 16'hBEEF;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        reset_n = 1'b0;
        #3;
        chk_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        send(14'h0010, 4, 1'b1);
        wait_done();

        rmode = 1;
        send(14'h0010, 4, 1'b0);
        wait_done();
        rmode = 0;

        send(14'h0020, 0, 1'b1);
        wait_done();

        send(14'h3FFE, 3, 1'b1);
        wait_done();

        rmode = 2;
        @(posedge clk);
        #2;
        send(14'h0300, 1, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        chk("hold_valid", bus.st_valid, 1);
        chk("hold_sop_eop", {bus.st_sop, bus.st_eop}, 3);
        chk("hold_data", bus.st_data, 16'hBEEF);
        chk("single_read", cmd_reads, 1);
        rmode = 0;
        wait_done();

        base = pops;
        send(14'h0100, 8, 1'b0);
        k = 0;
        while (pops < base + 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("mid_beats", pops - base, 2);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset();
        exp_q.delete();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        ndone_exp = dones;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;

        send(14'h0200, 2, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("queues_empty",
            exp_q.size() + exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
